// File: rtl/lab7_pkg.sv
// rtl/lab7_pkg.sv - shared bus encodings, I/O address map and display constants for lab 7
package lab7_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MRSVD  = 2'b11
    } mem_cmd_t;

    localparam logic [8:0] ADDR_LED  = 9'h100;
    localparam logic [8:0] ADDR_HEX  = 9'h120;
    localparam logic [8:0] ADDR_SW   = 9'h140;
    localparam logic [8:0] ADDR_STAT = 9'h141;

    localparam logic [6:0] HEX_BLANK = 7'b1111111;

endpackage

// File: rtl/lab7_mmio_sseg.sv
// rtl/lab7_mmio_sseg.sv - hex nibble to active-low seven-segment pattern
module sseg_decode (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/lab7_mmio.sv
// rtl/lab7_mmio.sv - lab 7 memory-mapped I/O: LED/HEX registers, switch sync/debounce, 1-cycle reads
// Optional debouncer enabled by defining MMIO_DEBOUNCE_EN.
module lab7_mmio
    import lab7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  sw_in,
    output logic        io_sel,
    output logic [15:0] io_read_data,
    output logic [7:0]  ledr,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    logic [15:0] hex_reg;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [7:0]  sw_stable;
    logic        sw_changed;
    logic        stable_load;

    logic        is_read;
    logic        is_write;
    logic        rd_hit;
    logic [15:0] rd_data;
    logic        stat_clear;

    assign is_read    = (mem_cmd == MREAD);
    assign is_write   = (mem_cmd == MWRITE);
    assign stat_clear = is_read && (mem_addr == ADDR_STAT);

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 16'h0000;
        if (is_read) begin
            case (mem_addr)
                ADDR_LED:  begin rd_hit = 1'b1; rd_data = {8'h00, ledr};          end
                ADDR_HEX:  begin rd_hit = 1'b1; rd_data = hex_reg;                end
                ADDR_SW:   begin rd_hit = 1'b1; rd_data = {8'h00, sw_stable};     end
                ADDR_STAT: begin rd_hit = 1'b1; rd_data = {15'h0000, sw_changed}; end
                default:   begin rd_hit = 1'b0; rd_data = 16'h0000;               end
            endcase
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    sw_prev;
    logic          db_hold;

    assign cnt_inc     = db_cnt + 1'b1;
    assign db_hold     = (sw_sync == sw_stable) || (sw_sync != sw_prev);
    // The cycle that starts a run counts as its first stable cycle, so the
    // load fires on the incremented count.
    assign stable_load = !db_hold && (cnt_inc >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt  <= '0;
            sw_prev <= 8'h00;
        end else begin
            sw_prev <= sw_sync;
            if (db_hold || stable_load)
                db_cnt <= '0;
            else
                db_cnt <= cnt_inc;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign stable_load = (sw_sync != sw_stable);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ledr         <= 8'h00;
            hex_reg      <= 16'h0000;
            io_sel       <= 1'b0;
            io_read_data <= 16'h0000;
            sw_meta      <= 8'h00;
            sw_sync      <= 8'h00;
            sw_stable    <= 8'h00;
            sw_changed   <= 1'b0;
        end else begin
            io_sel       <= rd_hit;
            io_read_data <= rd_data;
            sw_meta      <= sw_in;
            sw_sync      <= sw_meta;
            if (is_write && mem_addr == ADDR_LED)
                ledr <= write_data[7:0];
            if (is_write && mem_addr == ADDR_HEX)
                hex_reg <= write_data;
            if (stable_load)
                sw_stable <= sw_sync;
            // A fresh switch change outranks a status read clearing the flag.
            if (stable_load)
                sw_changed <= 1'b1;
            else if (stat_clear)
                sw_changed <= 1'b0;
        end
    end

    sseg_decode u_hex0 (.nibble(hex_reg[3:0]),   .seg(hex0));
    sseg_decode u_hex1 (.nibble(hex_reg[7:4]),   .seg(hex1));
    sseg_decode u_hex2 (.nibble(hex_reg[11:8]),  .seg(hex2));
    sseg_decode u_hex3 (.nibble(hex_reg[15:12]), .seg(hex3));

    assign hex4 = HEX_BLANK;
    assign hex5 = HEX_BLANK;

endmodule

// File: doc/lab7_mmio.md
# lab7_mmio

Memory-mapped I/O stage between the lab 7 CPU memory bus and the board I/O (SW, LEDR, HEX). It decodes CPU reads and writes that fall in the I/O address window. It holds the LED and 7-segment display registers, and synchronizes and debounces the slide switches. It returns switch and status data with the same one-cycle read latency as the RAM, so the top-level read mux treats both sources identically.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4 — consecutive stable cycles required before a switch change is accepted (≥1).

Ports:
- clk  in  1  — single rising-edge clock (KEY[0] inverted at top level)
- reset  in  1  — synchronous, active-high
- mem_cmd  in  2  — 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE; 2'b11 treated as MNONE
- mem_addr  in  9  — CPU bus address
- write_data  in  16  — CPU store data
- sw_in  in  8  — raw SW[7:0], asynchronous to clk
- io_sel  out  1  — registered; high the cycle after an MREAD hit a mapped I/O address
- io_read_data  out  16  — registered read data, valid when io_sel=1, else 16'h0000
- ledr  out  8  — LED register, drives LEDR[7:0]
- hex0..hex3  out  7 each  — active-low segments for hex_reg nibbles 0..3
- hex4, hex5  out  7 each  — constant 7'b1111111 (blank)

## Operation
- Address map:
  - 0x100 LED (R/W, bits 7:0)
  - 0x120 HEX (R/W, 16 bits)
  - 0x140 SW (R, debounced value zero-extended)
  - 0x141 STATUS (R, bit0 = sw_changed, other bits 0)
- Reads of LED return {8'h00, ledr}.
- Writes to 0x140/0x141 are ignored. Unmapped addresses: no register change, io_sel=0, io_read_data=0.
- LED write: ledr <= write_data[7:0]. HEX write: hex_reg <= write_data.
- Switch path: a two-flop synchronizer produces sw_sync, followed by the debouncer, which produces sw_stable.
- Debouncer:
  - Counter resets to 0 whenever sw_sync equals sw_stable, or whenever sw_sync differs from its own previous-cycle value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while a difference is present, sw_stable <= sw_sync and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- sw_changed flag:
  - Set on any cycle in which sw_stable updates to a different value.
  - Cleared by an MREAD of 0x141; the read returns the pre-clear value.
  - If a set and a clear occur in the same cycle, set wins.
- Segment decode: each nibble maps to 0–F with standard active-low patterns (0 → 7'b1000000, 1 → 7'b1111001, F → 7'b0001110).

## Timing
- Reset values: ledr=0, hex_reg=0 (hex0..3 show "0"), io_sel=0, io_read_data=0, synchronizer flops=0, sw_stable=0, counter=0, sw_changed=0.
- Write: ledr or hex_reg updates on the edge where mem_cmd=MWRITE; the new value is visible after that edge.
- Read: an MREAD sampled at edge N presents io_sel and io_read_data after edge N. This is 1-cycle latency, matching RAM.
- Back-to-back reads return data on consecutive cycles.
- Read-after-write to the same register in the next cycle returns the new value.
- Switch latency with debounce, from a clean sw_in change to sw_stable: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Reset asserted mid-operation: all state returns to reset values on that edge. A pending read result is dropped (io_sel=0).

## Configuration
- MMIO_DEBOUNCE_EN defined: the debouncer is as described.
- MMIO_DEBOUNCE_EN undefined: sw_stable <= sw_sync every cycle and no counter is built. Switch latency is 2 cycles + 1 register; sw_changed is still set on any sw_stable change.
- DEBOUNCE_CYCLES is unused when the macro is undefined.

## Structure
- Shared package lab7_pkg holds:
  - mem_cmd encodings MNONE, MREAD, MWRITE
  - address constants ADDR_LED=9'h100, ADDR_HEX=9'h120, ADDR_SW=9'h140, ADDR_STAT=9'h141
  - the HEX_BLANK constant
- Sub-module sseg_decode (4-bit in, 7-bit active-low out) is instantiated four times.
- The debouncer stays inline under the macro guard.

## Test plan
- Reset: hold reset 2 cycles → ledr=0, io_sel=0, hex0=7'b1000000, hex4=hex5=7'b1111111.
- LED write/read: MWRITE 0x100 data 16'h00A5, then MREAD 0x100 → ledr=8'hA5 and, next cycle, io_sel=1, io_read_data=16'h00A5.
- HEX write: MWRITE 0x120 data 16'h12EF → hex0=7'b0001110 (F), hex3=7'b1111001 (1).
- Debounce (macro on, DEBOUNCE_CYCLES=4): set sw_in=8'h0F.
  - sw_stable updates exactly 6 cycles later; MREAD 0x140 → 16'h000F.
  - A 2-cycle glitch to 8'hFF produces no change.
- Status: after the switch change, MREAD 0x141 → 16'h0001; a second read → 16'h0000. A change landing in the same cycle as the clearing read leaves sw_changed=1.
- Unmapped/read-only: MREAD 0x050 → io_sel=0, data 0. MWRITE 0x140 data 16'hFFFF → the SW read still returns the switch value and ledr is unchanged.
